// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares a single-ported memory between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_inst,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wen,
    input  logic [DATA_W-1:0] d_req_wmask,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic       grant_i, grant_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // Fetch only overtakes a pending data request once starvation saturates.
                if (d_req_valid && !(i_req_valid && starve_cnt == LIMIT)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_req_valid) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign mem_valid   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            mem_addr     <= '0;
            mem_wen      <= 1'b0;
            mem_wmask    <= '0;
            mem_wdata    <= '0;
            i_resp_valid <= 1'b0;
            i_resp_inst  <= '0;
            d_resp_valid <= 1'b0;
            d_resp_rdata <= '0;
        end else begin
            state <= state_nxt;

            if (grant_i) begin
                starve_cnt <= 4'd0;
                mem_addr   <= i_req_addr;
                mem_wen    <= 1'b0;
                mem_wmask  <= '0;
                mem_wdata  <= '0;
            end else if (grant_d) begin
                starve_cnt <= i_req_valid ? sat_inc(starve_cnt) : 4'd0;
                mem_addr   <= d_req_addr;
                mem_wen    <= d_req_wen;
                mem_wmask  <= d_req_wen ? d_req_wmask : '0;
                mem_wdata  <= d_req_wen ? d_req_wdata : '0;
            end

            // Response stage: one-cycle pulse, payload held until the next capture.
            i_resp_valid <= (state == BUSY_I) && mem_ready;
            d_resp_valid <= (state == BUSY_D) && mem_ready;
            if ((state == BUSY_I) && mem_ready) i_resp_inst <= mem_rdata;
            if ((state == BUSY_D) && mem_ready) d_resp_rdata <= mem_wen ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses plus hand sequences for arbitration, counter clear and reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [31:0] i_resp_inst;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_wen;
    logic [31:0] d_req_wmask;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_inst(i_resp_inst),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wen(d_req_wen),
        .d_req_wmask(d_req_wmask), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [31:0] mrd;
        logic [31:0] exp_data;
        logic [31:0] exp_wmask;
        logic [31:0] exp_wdata;
        int          waits;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } resp_t;

    resp_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    arb_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_readys"}, {i_req_ready, d_req_ready}, 0);
        chk({tag, "_resp_valids"}, {i_resp_valid, d_resp_valid}, 0);
        chk({tag, "_i_resp_inst"}, i_resp_inst, 0);
        chk({tag, "_d_resp_rdata"}, d_resp_rdata, 0);
    endtask

    // Pops the scoreboard and checks the pulse lands on the expected port with the expected payload.
    task automatic chk_resp();
        resp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_scoreboard_empty: got i=%0b d=%0b required an expected entry", i_resp_valid, d_resp_valid);
            return;
        end
        e = sb_q.pop_front();
        chk("resp_i_valid", i_resp_valid, !e.is_d);
        chk("resp_d_valid", d_resp_valid, e.is_d);
        if (e.is_d) chk("resp_d_rdata", d_resp_rdata, e.data);
        else        chk("resp_i_inst", i_resp_inst, e.data);
    endtask

    task automatic run_access(input vec_t v);
        resp_t r;
        i_req_valid = !v.is_d;
        i_req_addr  = v.addr;
        d_req_valid = v.is_d;
        d_req_addr  = v.addr;
        d_req_wen   = v.wen;
        d_req_wmask = v.wmask;
        d_req_wdata = v.wdata;
        #1;
        chk("i_req_ready", i_req_ready, !v.is_d);
        chk("d_req_ready", d_req_ready, v.is_d);
        r.is_d = v.is_d;
        r.data = v.exp_data;
        sb_q.push_back(r);
        @(negedge clk);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        d_req_wdata = 32'h5555_AAAA;
        d_req_wmask = 32'hFFFF_FFFF;
        for (int w = 0; w <= v.waits; w++) begin
            #1;
            chk("busy_mem_valid", mem_valid, 1);
            chk("busy_mem_addr", mem_addr, v.addr);
            chk("busy_mem_wen", mem_wen, v.is_d && v.wen);
            chk("busy_mem_wmask", mem_wmask, v.exp_wmask);
            chk("busy_mem_wdata", mem_wdata, v.exp_wdata);
            chk("busy_no_resp", {i_resp_valid, d_resp_valid}, 0);
            if (w == v.waits) begin
                mem_ready = 1'b1;
                mem_rdata = v.mrd;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_0000 + 32'(w);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk_resp();
    endtask

    // One arbitration round with the given request pattern; memory answers one cycle after accept.
    task automatic arb_step(input bit iv, input bit dv, input bit exp_d, input string tag);
        resp_t       r;
        logic [31:0] val;
        i_req_valid = iv;
        d_req_valid = dv;
        i_req_addr  = 32'h0000_1000;
        d_req_addr  = 32'h0000_2000;
        d_req_wen   = 1'b0;
        d_req_wmask = 32'h0;
        #1;
        chk({tag, "_gnt_d"}, d_req_ready, exp_d);
        chk({tag, "_gnt_i"}, i_req_ready, !exp_d);
        arb_n++;
        val    = 32'hA5A5_0000 + 32'(arb_n);
        r.is_d = exp_d;
        r.data = val;
        sb_q.push_back(r);
        @(negedge clk);
        #1;
        chk({tag, "_busy_readys"}, {i_req_ready, d_req_ready}, 0);
        chk({tag, "_busy_addr"}, mem_addr, exp_d ? 32'h0000_2000 : 32'h0000_1000);
        mem_ready = 1'b1;
        mem_rdata = val;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk_resp();
    endtask

    vec_t vecs[7];
    bit   arb_exp[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_addr = 0; d_req_wen = 0; d_req_wmask = 0; d_req_wdata = 0;
        mem_rdata = 0; mem_ready = 0;

        //           is_d wen addr          wdata          wmask          mrd            exp_data       exp_wmask      exp_wdata     waits
        vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         32'h0,         32'h0010_0093, 32'h0010_0093, 32'h0,         32'h0,         0};
        vecs[1] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h1234_5678, 32'h0,         32'h0000_FFFF, 32'hDEAD_BEEF, 3};
        vecs[2] = '{1, 0, 32'h0000_0200, 32'h1111_2222, 32'hFFFF_0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0,         32'h0,         1};
        vecs[3] = '{0, 0, 32'h0000_0040, 32'h0,         32'h0,         32'h00A0_0513, 32'h00A0_0513, 32'h0,         32'h0,         2};
        vecs[4] = '{0, 0, 32'h0000_0000, 32'h0,         32'h0,         32'h0000_0001, 32'h0000_0001, 32'h0,         32'h0,         0};
        vecs[5] = '{0, 0, 32'h0000_0004, 32'h0,         32'h0,         32'h0000_0002, 32'h0000_0002, 32'h0,         32'h0,         0};
        vecs[6] = '{0, 0, 32'h0000_0008, 32'h0,         32'h0,         32'h0000_0003, 32'h0000_0003, 32'h0,         32'h0,         0};

        arb_exp = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("post_reset");

        // mem_ready in IDLE must not produce a response.
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("idle_ready_ignored", {i_resp_valid, d_resp_valid, mem_valid}, 0);
        @(negedge clk);
        #1;

        for (int k = 0; k < 7; k++) run_access(vecs[k]);

        // Response payloads hold after the pulse.
        @(negedge clk);
        #1;
        chk("hold_i_resp_inst", i_resp_inst, 32'h0000_0003);
        chk("hold_d_resp_rdata", d_resp_rdata, 32'hCAFE_F00D);
        chk("hold_no_pulse", {i_resp_valid, d_resp_valid}, 0);

        for (int k = 0; k < 12; k++) arb_step(1'b1, 1'b1, arb_exp[k], $sformatf("arb%0d", k));

        // Clear the counter with a fetch-only grant, then exercise the data-only clear.
        arb_step(1'b1, 1'b0, 1'b0, "clr_fetch");
        for (int k = 0; k < 3; k++) arb_step(1'b1, 1'b1, 1'b1, $sformatf("clr_a%0d", k));
        arb_step(1'b0, 1'b1, 1'b1, "clr_donly");
        for (int k = 0; k < 4; k++) arb_step(1'b1, 1'b1, 1'b1, $sformatf("clr_b%0d", k));
        arb_step(1'b1, 1'b1, 1'b0, "clr_fetch_due");
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;

        // Reset while a data access is in flight: aborted, no response.
        d_req_valid = 1'b1; d_req_addr = 32'h0000_0300; d_req_wen = 1'b1;
        d_req_wmask = 32'hFFFF_FFFF; d_req_wdata = 32'h0BAD_CAFE;
        #1;
        chk("rst_mid_accept", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        chk("rst_mid_busy", mem_valid, 1);
        chk("rst_mid_busy_addr", mem_addr, 32'h0000_0300);
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", mem_valid, 0);
        @(negedge clk);
        #1;
        chk_all_zero("rst_mid_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        @(negedge clk);
        #1;
        chk_all_zero("rst_mid_release");
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        run_access(vecs[0]);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
